// File: rtl/fb_pixel_server.sv
// fb_pixel_server -- serves 24-bit RGB pixels to a VGA scan-out engine from a
// grayscale (one byte per pixel) framebuffer held in shared data memory.
//
// Ports:
//   clk50MHz   in   1   sole clock, rising edge
//   rst        in   1   asynchronous, active-low reset
//   px_addr    in  32   pixel index requested by the VGA side
//   memPx      out 24   registered RGB pixel ({g,g,g})
//   px_valid   out  1   memPx belongs to the current (registered) px_addr
//   mem_rd_en  out  1   read request, held until mem_gnt
//   mem_gnt    in   1   memory accepts the request this cycle
//   mem_addr   out 16   byte address, stable while mem_rd_en is high
//   mem_rdata  in   8   read data, valid MEM_LAT cycles after acceptance
//   miss_cnt   out 16   saturating count of fetches that reached memory
//
// Optional feature: define FB_PREFETCH_EN to add a one-entry prefetch buffer
// that fetches the pixel following each demand fetch.
module fb_pixel_server #(
  parameter logic [15:0] FB_BASE      = 16'h0000,
  parameter int unsigned FB_PIXELS    = 76800,
  parameter logic [23:0] BORDER_COLOR = 24'h000000,
  parameter int unsigned MEM_LAT      = 1
) (
  input  logic        clk50MHz,
  input  logic        rst,
  input  logic [31:0] px_addr,
  output logic [23:0] memPx,
  output logic        px_valid,
  output logic        mem_rd_en,
  input  logic        mem_gnt,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] miss_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, LATCH} state_t;

  localparam logic [31:0] PIX_LIMIT = 32'(FB_PIXELS);
  localparam logic [2:0]  LAT_LOAD  = 3'(MEM_LAT - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_addr_q;
  logic [31:0] r_tag_q;
  logic [31:0] r_fetch_addr;
  logic [15:0] r_mem_addr;
  logic [23:0] r_px;
  logic        r_valid;
  logic [15:0] r_miss;
  logic [2:0]  r_lat_cnt;

  logic        w_start;
  logic [31:0] w_req_addr;
  logic        w_border;
  logic        w_hit;

`ifdef FB_PREFETCH_EN
  logic        r_is_pf;
  logic [31:0] r_pf_addr;
  logic [23:0] r_pf_data;
  logic        r_pf_valid;
  logic        w_req_pf;
  logic        w_pf_hit;
`endif

  function automatic logic in_range(input logic [31:0] a);
    return a < PIX_LIMIT;
  endfunction

  always_ff @(posedge clk50MHz or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_req_addr  = r_addr_q;
    w_border    = 1'b0;
    w_hit       = 1'b0;
`ifdef FB_PREFETCH_EN
    w_req_pf    = 1'b0;
    w_pf_hit    = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (r_addr_q != r_tag_q) begin
`ifdef FB_PREFETCH_EN
          if (r_pf_valid && (r_addr_q == r_pf_addr)) begin
            // Buffer hit: serve it now and keep streaming one pixel ahead.
            w_pf_hit = 1'b1;
            if (in_range(r_addr_q + 32'd1)) begin
              w_start     = 1'b1;
              w_req_addr  = r_addr_q + 32'd1;
              w_req_pf    = 1'b1;
              w_state_nxt = REQ;
            end
          end else
`endif
          if (in_range(r_addr_q)) begin
            w_start     = 1'b1;
            w_state_nxt = REQ;
          end else begin
            w_border = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_gnt) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_lat_cnt == 3'd0) w_state_nxt = LATCH;
      end
      LATCH: begin
        w_state_nxt = IDLE;
`ifdef FB_PREFETCH_EN
        if (r_is_pf) begin
          w_state_nxt = IDLE;
        end else
`endif
        if (r_fetch_addr == r_addr_q) begin
          w_hit = 1'b1;
`ifdef FB_PREFETCH_EN
          if (in_range(r_fetch_addr + 32'd1)) begin
            w_start     = 1'b1;
            w_req_addr  = r_fetch_addr + 32'd1;
            w_req_pf    = 1'b1;
            w_state_nxt = REQ;
          end
`endif
        end else if ((r_addr_q != r_tag_q) && in_range(r_addr_q)) begin
          // Stale data: skip IDLE and refetch for the address now wanted.
          w_start     = 1'b1;
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk50MHz or negedge rst) begin
    if (!rst) begin
      r_addr_q     <= '0;
      r_tag_q      <= '1;
      r_fetch_addr <= '0;
      r_mem_addr   <= '0;
      r_px         <= '0;
      r_valid      <= 1'b0;
      r_miss       <= '0;
      r_lat_cnt    <= '0;
`ifdef FB_PREFETCH_EN
      r_is_pf      <= 1'b0;
      r_pf_addr    <= '0;
      r_pf_data    <= '0;
      r_pf_valid   <= 1'b0;
`endif
    end else begin
      r_addr_q <= px_addr;

      if (w_start) begin
        r_fetch_addr <= w_req_addr;
        r_mem_addr   <= FB_BASE + w_req_addr[15:0];
`ifdef FB_PREFETCH_EN
        r_is_pf      <= w_req_pf;
`endif
      end

      if ((r_state == REQ) && mem_gnt) r_lat_cnt <= LAT_LOAD;
      else if ((r_state == WAIT) && (r_lat_cnt != 3'd0)) r_lat_cnt <= r_lat_cnt - 3'd1;

      if (w_border) begin
        r_px    <= BORDER_COLOR;
        r_tag_q <= r_addr_q;
        r_valid <= 1'b1;
      end

      if (w_hit) begin
        r_px    <= {3{mem_rdata}};
        r_tag_q <= r_fetch_addr;
        r_valid <= 1'b1;
      end

      if ((r_state == LATCH) && (r_miss != 16'hFFFF)) r_miss <= r_miss + 16'd1;

`ifdef FB_PREFETCH_EN
      if ((r_state == LATCH) && r_is_pf) begin
        r_pf_addr  <= r_fetch_addr;
        r_pf_data  <= {3{mem_rdata}};
        r_pf_valid <= 1'b1;
      end
      if (w_pf_hit) begin
        r_px       <= r_pf_data;
        r_tag_q    <= r_addr_q;
        r_valid    <= 1'b1;
        r_pf_valid <= 1'b0;
      end
`endif
    end
  end

  assign memPx     = r_px;
  assign px_valid  = r_valid && (r_addr_q == r_tag_q);
  assign mem_rd_en = (r_state == REQ);
  assign mem_addr  = r_mem_addr;
  assign miss_cnt  = r_miss;

endmodule

// File: tb/tb_fb_pixel_server.sv
// tb_fb_pixel_server -- directed self-checking bench for fb_pixel_server
// (default build, MEM_LAT=1). The memory model returns byte (addr[7:0]+8'h53)
// MEM_LAT cycles after a granted read, so pixel 7 reads 8'h5A.
module tb_fb_pixel_server;

  logic        clk;
  logic        rst;
  logic [31:0] px_addr;
  logic [23:0] memPx;
  logic        px_valid;
  logic        mem_rd_en;
  logic        mem_gnt;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [15:0] miss_cnt;

  logic [15:0] gnt_addr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  fb_pixel_server #(
    .BORDER_COLOR(24'hC0FFEE)
  ) dut (
    .clk50MHz (clk),
    .rst      (rst),
    .px_addr  (px_addr),
    .memPx    (memPx),
    .px_valid (px_valid),
    .mem_rd_en(mem_rd_en),
    .mem_gnt  (mem_gnt),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .miss_cnt (miss_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en && mem_gnt) gnt_addr <= mem_addr;
  end
  assign mem_rdata = gnt_addr[7:0] + 8'h53;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    gnt_addr = '0;
    rst      = 1'b0;
    px_addr  = 32'd0;
    mem_gnt  = 1'b1;
    tick(3);
    check_eq("rst_memPx",  32'(memPx),     32'h0);
    check_eq("rst_valid",  32'(px_valid),  32'h0);
    check_eq("rst_rd_en",  32'(mem_rd_en), 32'h0);
    check_eq("rst_addr",   32'(mem_addr),  32'h0);
    check_eq("rst_miss",   32'(miss_cnt),  32'h0);

    // Pixel 0 is fetched straight out of reset.
    rst = 1'b1;
    tick(8);
    check_eq("p0_memPx", 32'(memPx),    32'h535353);
    check_eq("p0_valid", 32'(px_valid), 32'h1);
    check_eq("p0_miss",  32'(miss_cnt), 32'd1);

    // 0 -> 7: five-cycle miss latency.
    px_addr = 32'd7;
    tick(1);
    check_eq("p7_drop",  32'(px_valid),  32'h0);
    tick(1);
    check_eq("p7_rd_en", 32'(mem_rd_en), 32'h1);
    check_eq("p7_addr",  32'(mem_addr),  32'h0007);
    tick(2);
    check_eq("p7_early", 32'(px_valid),  32'h0);
    tick(1);
    check_eq("p7_valid", 32'(px_valid),  32'h1);
    check_eq("p7_memPx", 32'(memPx),     32'h5A5A5A);
    check_eq("p7_miss",  32'(miss_cnt),  32'd2);

    // Grant withheld for 6 cycles.
    mem_gnt = 1'b0;
    px_addr = 32'd20;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      check_eq("stall_rd_en", 32'(mem_rd_en), 32'h1);
      check_eq("stall_addr",  32'(mem_addr),  32'h0014);
      tick(1);
    end
    mem_gnt = 1'b1;
    tick(1);
    check_eq("stall_wait_rd", 32'(mem_rd_en), 32'h0);
    tick(1);
    check_eq("stall_early", 32'(px_valid), 32'h0);
    tick(1);
    check_eq("stall_valid", 32'(px_valid), 32'h1);
    check_eq("stall_memPx", 32'(memPx),    32'h676767);
    check_eq("stall_miss",  32'(miss_cnt), 32'd3);

    // First out-of-range index: border colour, no memory access.
    px_addr = 32'd76800;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_eq("oor_rd_en", 32'(mem_rd_en), 32'h0);
    end
    check_eq("oor_memPx", 32'(memPx),    32'hC0FFEE);
    check_eq("oor_valid", 32'(px_valid), 32'h1);
    check_eq("oor_miss",  32'(miss_cnt), 32'd3);

    // Last in-range index: address wraps to 16 bits.
    px_addr = 32'd76799;
    tick(2);
    check_eq("last_addr", 32'(mem_addr), 32'h2BFF);
    tick(3);
    check_eq("last_valid", 32'(px_valid), 32'h1);
    check_eq("last_memPx", 32'(memPx),    32'h525252);
    check_eq("last_miss",  32'(miss_cnt), 32'd4);

    // 10 -> 11 while WAIT: stale byte dropped, refetch of 11.
    px_addr = 32'd10;
    tick(3);
    px_addr = 32'd11;
    tick(2);
    check_eq("chg_valid", 32'(px_valid),  32'h0);
    check_eq("chg_keep",  32'(memPx),     32'h525252);
    check_eq("chg_miss1", 32'(miss_cnt),  32'd5);
    check_eq("chg_rd_en", 32'(mem_rd_en), 32'h1);
    check_eq("chg_addr",  32'(mem_addr),  32'h000B);
    tick(3);
    check_eq("chg_valid2", 32'(px_valid), 32'h1);
    check_eq("chg_memPx",  32'(memPx),    32'h5E5E5E);
    check_eq("chg_miss2",  32'(miss_cnt), 32'd6);

    // Repeated address never fetches.
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_eq("hold_rd_en", 32'(mem_rd_en), 32'h0);
    end
    check_eq("hold_miss", 32'(miss_cnt), 32'd6);

    // Reset pulsed during WAIT.
    px_addr = 32'd30;
    tick(3);
    rst = 1'b0;
    #1;
    check_eq("mrst_memPx", 32'(memPx),     32'h0);
    check_eq("mrst_valid", 32'(px_valid),  32'h0);
    check_eq("mrst_rd_en", 32'(mem_rd_en), 32'h0);
    check_eq("mrst_addr",  32'(mem_addr),  32'h0);
    check_eq("mrst_miss",  32'(miss_cnt),  32'h0);
    tick(1);
    rst = 1'b1;
    tick(12);
    check_eq("post_valid", 32'(px_valid), 32'h1);
    check_eq("post_memPx", 32'(memPx),    32'h717171);
    check_eq("post_miss",  32'(miss_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_pixel_server.md
FB_PIXEL_SERVER -- requirements
Module: fb_pixel_server

Interface
REQ-001 SHALL have parameter FB_BASE, default 16'h0000: data-memory byte address of framebuffer pixel 0.
REQ-002 SHALL have parameter FB_PIXELS, default 76800: pixel count (320x240); addresses at or above it are out of range.
REQ-003 SHALL have parameter BORDER_COLOR, default 24'h000000: pixel returned for out-of-range addresses.
REQ-004 SHALL have parameter MEM_LAT, default 1: cycles from accepted read to valid mem_rdata, range 1-4.
REQ-005 SHALL have port clk50MHz, input, 1: sole clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port px_addr, input, 32: pixel index requested by the VGA side.
REQ-008 SHALL have port memPx, output, 24: RGB pixel returned to the VGA side, registered.
REQ-009 SHALL have port px_valid, output, 1: memPx holds the pixel for the current px_addr.
REQ-010 SHALL have ports mem_rd_en (output, 1), mem_gnt (input, 1), mem_addr (output, 16) and mem_rdata (input, 8): read port to shared data memory, one grayscale byte per pixel.
REQ-011 SHALL have port miss_cnt, output, 16: saturating count of fetches that reached memory.

Function
REQ-012 SHALL register px_addr into addr_q every cycle; px_valid SHALL drop in the cycle after px_addr differs from the address memPx belongs to (tag_q).
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT, LATCH.
- IDLE->REQ: the cycle after addr_q != tag_q and the address is in range.
REQ-014 Out-of-range address in IDLE SHALL load memPx=BORDER_COLOR, tag_q=addr_q and px_valid=1 in one cycle, with no memory access and no miss_cnt change.
REQ-015 In REQ, mem_rd_en SHALL be 1 and mem_addr SHALL be FB_BASE+addr_q[15:0] (mod 2^16); the FSM SHALL hold REQ with stable mem_addr until mem_gnt=1, then go to WAIT.
REQ-016 WAIT SHALL last exactly MEM_LAT cycles, then go to LATCH; mem_rd_en SHALL be 0 outside REQ.
REQ-017 LATCH SHALL set memPx={mem_rdata,mem_rdata,mem_rdata}, tag_q to the fetched address, px_valid=1, increment miss_cnt (saturating at 16'hFFFF), then return to IDLE.
REQ-018 If px_addr changes during REQ, WAIT or LATCH, the fetch SHALL complete; LATCH SHALL update memPx only if the fetched address still equals addr_q, else discard the data, keep px_valid=0 and go directly to REQ for the new address.
REQ-019 With mem_gnt=1 and MEM_LAT=1, miss latency from the px_addr change to px_valid=1 SHALL be 5 cycles.
REQ-020 px_addr equal to tag_q SHALL never start a fetch.

Reset
REQ-021 rst=0 SHALL asynchronously force state=IDLE, memPx=0, px_valid=0, mem_rd_en=0, mem_addr=0, miss_cnt=0, addr_q=0, tag_q=32'hFFFFFFFF; prefetch buffer invalid.
REQ-022 Reset asserted mid-fetch SHALL abandon the fetch; the first fetch after release SHALL restart from IDLE.

Configuration
REQ-023 Macro FB_PREFETCH_EN SHALL enable a one-entry prefetch buffer (pf_addr, pf_data, pf_valid).
REQ-024 With FB_PREFETCH_EN, after each LATCH the FSM SHALL fetch tag_q+1 (if in range) into the buffer by the same REQ/WAIT sequence, counted in miss_cnt.
REQ-025 With FB_PREFETCH_EN, addr_q==pf_addr with pf_valid=1 SHALL load memPx from the buffer, set px_valid=1 one cycle after addr_q updates, and clear pf_valid.
REQ-026 With FB_PREFETCH_EN, a px_addr change during a prefetch SHALL let the prefetch finish, then apply REQ-025 or REQ-013.
REQ-027 Without FB_PREFETCH_EN, no buffer logic SHALL exist and behaviour SHALL be REQ-012..REQ-020 only.

Verification
REQ-028 mem_rdata=8'h5A, mem_gnt=1, px_addr 0->7: mem_addr=16'h0007, then memPx=24'h5A5A5A with px_valid=1 after 5 cycles; miss_cnt=1.
REQ-029 mem_gnt held 0 for 6 cycles: mem_rd_en stays 1 and mem_addr stays stable; the response is delayed exactly 6 cycles.
REQ-030 px_addr=76800: memPx=BORDER_COLOR with px_valid=1; mem_rd_en never asserts; miss_cnt unchanged.
REQ-031 px_addr 10->11 during WAIT: the byte for 10 is discarded and memPx ends as pixel 11 data; miss_cnt=2.
REQ-032 rst pulsed low during WAIT: outputs are immediately at reset values; the next request completes normally.
REQ-033 FB_PREFETCH_EN, sequential px_addr 0,1,2 spaced 8 cycles: pixels 1 and 2 give px_valid=1 two cycles after the change.
